// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock generator with run/stop sequencing and glitch-free reconfiguration.
// Optional define CLKGEN_SYNC_RUN_EN inserts a 2-flop synchroniser on run ahead of the sequencer.
module clock_enable_gen #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8,
   parameter int CH_W   = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic [CNT_W-1:0]  cfg_phase,
   input  logic              cfg_inv,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic              locked
);

   // state | meaning
   // IDLE  | outputs parked at idle level, cfg writes land in active regs
   // START | single cycle, counters load the clamped phase
   // RUN   | channels free-running, cfg writes staged until period end
   // STOP  | channels finish their active half, then freeze at idle level
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_RUN   = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic   run_int;

`ifdef CLKGEN_SYNC_RUN_EN
   logic [1:0] run_sync_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) run_sync_q <= '0;
      else        run_sync_q <= {run_sync_q[0], run};
   end

   assign run_int = run_sync_q[1];
`else
   assign run_int = run;
`endif

   logic [CNT_W-1:0]  div_q   [NUM_CH];
   logic [CNT_W-1:0]  div_d   [NUM_CH];
   logic [CNT_W-1:0]  phase_q [NUM_CH];
   logic [CNT_W-1:0]  phase_d [NUM_CH];
   logic [CNT_W-1:0]  sdiv_q  [NUM_CH];
   logic [CNT_W-1:0]  sdiv_d  [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] inv_q, inv_d;
   logic [NUM_CH-1:0] sinv_q, sinv_d;
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] clk_q, clk_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] cfg_hit;
   logic [NUM_CH-1:0] at_end;
   logic              cfg_acc;
   logic              all_idle;

   assign cfg_ready = ~|pend_q;
   assign cfg_acc   = cfg_valid & cfg_ready;
   assign all_idle  = (clk_q == inv_q);
   assign clk_out   = clk_q;
   assign tick      = tick_q;
   assign locked    = (state_q == S_RUN) && ~|pend_q;

   // Out-of-range channel numbers never match, so such writes complete and vanish.
   always_comb begin
      cfg_hit = '0;
      at_end  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cfg_hit[i] = cfg_acc && (cfg_ch == CH_W'(i));
         at_end[i]  = (cnt_q[i] >= div_q[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (run_int) state_d = S_START;
         S_START: state_d = S_RUN;
         S_RUN:   if (!run_int) state_d = S_STOP;
         S_STOP:  if (all_idle) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      inv_d  = inv_q;
      sinv_d = sinv_q;
      pend_d = pend_q;
      clk_d  = clk_q;
      tick_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         div_d[i]   = div_q[i];
         phase_d[i] = phase_q[i];
         sdiv_d[i]  = sdiv_q[i];
         cnt_d[i]   = cnt_q[i];

         case (state_q)
            S_IDLE: begin
               cnt_d[i] = '0;
               clk_d[i] = inv_q[i];
            end
            S_START: begin
               cnt_d[i] = (phase_q[i] > div_q[i]) ? div_q[i] : phase_q[i];
               clk_d[i] = inv_q[i];
            end
            S_RUN, S_STOP: begin
               if (state_q == S_STOP && clk_q[i] == inv_q[i]) begin
                  cnt_d[i] = '0;
                  if (pend_q[i]) begin
                     div_d[i]  = sdiv_q[i];
                     inv_d[i]  = sinv_q[i];
                     clk_d[i]  = sinv_q[i];
                     pend_d[i] = 1'b0;
                  end
               end else if (at_end[i]) begin
                  cnt_d[i] = '0;
                  // Swap config only at the end of the active half so no runt pulse appears.
                  if (pend_q[i] && clk_q[i] != inv_q[i]) begin
                     div_d[i]  = sdiv_q[i];
                     inv_d[i]  = sinv_q[i];
                     clk_d[i]  = sinv_q[i];
                     pend_d[i] = 1'b0;
                  end else begin
                     clk_d[i]  = ~clk_q[i];
                     tick_d[i] = (clk_q[i] == inv_q[i]);
                  end
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: ;
         endcase

         if (cfg_hit[i]) begin
            phase_d[i] = cfg_phase;
            sdiv_d[i]  = cfg_div;
            sinv_d[i]  = cfg_inv;
            if (state_q == S_RUN) begin
               pend_d[i] = 1'b1;
            end else begin
               div_d[i] = cfg_div;
               inv_d[i] = cfg_inv;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         inv_q   <= '0;
         sinv_q  <= '0;
         pend_q  <= '0;
         clk_q   <= '0;
         tick_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]   <= '0;
            phase_q[i] <= '0;
            sdiv_q[i]  <= '0;
            cnt_q[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         inv_q   <= inv_d;
         sinv_q  <= sinv_d;
         pend_q  <= pend_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i]   <= div_d[i];
            phase_q[i] <= phase_d[i];
            sdiv_q[i]  <= sdiv_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

endmodule
